// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the 8-bit CPU: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with datapath strobes.
// Optional CPU_CTRL_PERF_EN adds retired-instruction and active-cycle counters.
module cpu_control_unit #(
    parameter int STATE_W        = 3,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [7:0]         instruction_in,
    output logic               reg_write,
    output logic               mem_write,
    output logic               alu_src,
    output logic               pc_write,
    output logic [2:0]         alu_op,
    output logic               mem_to_reg,
    output logic               halted,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
`ifdef CPU_CTRL_PERF_EN
    ,
    output logic [15:0]        instr_retired,
    output logic [15:0]        cycle_count
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       illegal_q, illegal_d;

    logic [3:0] opcode;
    logic       op_alu, op_ld, op_st, op_hlt, op_undef;
    logic       ir_operand_unused;

    assign opcode            = ir_q[7:4];
    assign op_alu            = (opcode >= 4'h1) && (opcode <= 4'h6);
    assign op_ld             = (opcode == 4'h7);
    assign op_st             = (opcode == 4'h8);
    assign op_hlt            = (opcode == 4'hF);
    assign op_undef          = (opcode >= 4'h9) && (opcode <= 4'hE);
    // Register operand fields are consumed by the datapath, not by the sequencer.
    assign ir_operand_unused = ^ir_q[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            ir_q      <= 8'h00;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        alu_op     = 3'b000;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;

        // Operand-select fields stay stable for the whole execute phase of the instruction.
        if (state_q == EXEC || state_q == MEM || state_q == WB) begin
            case (opcode)
                4'h2:    alu_op     = 3'b001;
                4'h3:    alu_op     = 3'b010;
                4'h4:    alu_op     = 3'b011;
                4'h5:    alu_op     = 3'b100;
                4'h6:    alu_src    = 1'b1;
                4'h7:    mem_to_reg = 1'b1;
                default: ;
            endcase
        end

        case (state_q)
            FETCH: begin
                if (run) state_d = DECODE;
            end
            DECODE: begin
                ir_d    = instruction_in;
                state_d = EXEC;
            end
            EXEC: begin
                if (op_undef) illegal_d = 1'b1;
                if (op_alu) begin
                    state_d = WB;
                end else if (op_ld || op_st) begin
                    state_d = MEM;
                end else if (op_hlt || (op_undef && !ILLEGAL_AS_NOP)) begin
                    state_d = HALT;
                end else begin
                    pc_write = 1'b1;
                    state_d  = FETCH;
                end
            end
            MEM: begin
                if (op_ld) begin
                    state_d = WB;
                end else begin
                    mem_write = op_st;
                    pc_write  = 1'b1;
                    state_d   = FETCH;
                end
            end
            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign halted     = (state_q == HALT);
    assign illegal_op = illegal_q;
    assign state_out  = STATE_W'(state_q);

`ifdef CPU_CTRL_PERF_EN
    logic [15:0] retired_q, cycles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= 16'h0000;
            cycles_q  <= 16'h0000;
        end else begin
            if (pc_write) retired_q <= retired_q + 16'd1;
            if (state_q != HALT) cycles_q <= cycles_q + 16'd1;
        end
    end

    assign instr_retired = retired_q;
    assign cycle_count   = cycles_q;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized bench for cpu_control_unit: two instances (undefined opcode halts / retires as NOP)
// checked every cycle against an instruction-path reference model.
module tb_cpu_control_unit;

    logic       clk            = 1'b0;
    logic       reset          = 1'b0;
    logic       run            = 1'b0;
    logic [7:0] instruction_in = 8'h00;

    logic [2:0] st   [2];
    logic [2:0] aop  [2];
    logic       rw   [2];
    logic       mw   [2];
    logic       asrc [2];
    logic       pw   [2];
    logic       m2r  [2];
    logic       hlt  [2];
    logic       ill  [2];
`ifdef CPU_CTRL_PERF_EN
    logic [15:0] ret [2];
    logic [15:0] cyc [2];
    int          m_ret [2];
    int          m_cyc [2];
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = undefined opcodes halt, index 1 = undefined opcodes retire.
    int         m_st   [2];
    logic [7:0] m_ir   [2];
    bit         m_ill  [2];
    int         m_path [2][4];
    int         m_n    [2];
    int         m_k    [2];
    int         halt_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_control_unit #(
            .STATE_W       (3),
            .ILLEGAL_AS_NOP(g == 1)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .run           (run),
            .instruction_in(instruction_in),
            .reg_write     (rw[g]),
            .mem_write     (mw[g]),
            .alu_src       (asrc[g]),
            .pc_write      (pw[g]),
            .alu_op        (aop[g]),
            .mem_to_reg    (m2r[g]),
            .halted        (hlt[g]),
            .illegal_op    (ill[g]),
            .state_out     (st[g])
`ifdef CPU_CTRL_PERF_EN
            ,
            .instr_retired (ret[g]),
            .cycle_count   (cyc[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {alu_op, alu_src, mem_to_reg} per opcode
    function automatic logic [4:0] fields(input logic [3:0] op);
        case (op)
            4'h2:    return 5'b001_0_0;
            4'h3:    return 5'b010_0_0;
            4'h4:    return 5'b011_0_0;
            4'h5:    return 5'b100_0_0;
            4'h6:    return 5'b000_1_0;
            4'h7:    return 5'b000_0_1;
            default: return 5'b000_0_0;
        endcase
    endfunction

    function automatic bit undef_op(input logic [3:0] op);
        return (op >= 4'h9) && (op <= 4'hE);
    endfunction

    // States visited after DECODE, ending in FETCH (retired) or HALT.
    task automatic set_path(input int i, input logic [3:0] op);
        m_k[i] = 0;
        if (op >= 4'h1 && op <= 4'h6) begin
            m_path[i][0] = 2; m_path[i][1] = 4; m_path[i][2] = 0; m_n[i] = 3;
        end else if (op == 4'h7) begin
            m_path[i][0] = 2; m_path[i][1] = 3; m_path[i][2] = 4; m_path[i][3] = 0; m_n[i] = 4;
        end else if (op == 4'h8) begin
            m_path[i][0] = 2; m_path[i][1] = 3; m_path[i][2] = 0; m_n[i] = 3;
        end else if (op == 4'hF || (undef_op(op) && i == 0)) begin
            m_path[i][0] = 2; m_path[i][1] = 5; m_n[i] = 2;
        end else begin
            m_path[i][0] = 2; m_path[i][1] = 0; m_n[i] = 2;
        end
    endtask

    function automatic logic [15:0] expv(input int i);
        logic [3:0] op;
        logic [4:0] f;
        bit         ex;
        bit         pwe;
        op  = m_ir[i][7:4];
        ex  = (m_st[i] >= 2) && (m_st[i] <= 4);
        f   = ex ? fields(op) : 5'd0;
        pwe = 1'b0;
        if (ex && m_k[i] < m_n[i]) pwe = (m_path[i][m_k[i]] == 0);
        return {3'b000, 3'(m_st[i]), m_st[i] == 4, m_st[i] == 3 && op == 4'h8, f[1], pwe,
                f[4:2], f[0], m_st[i] == 5, m_ill[i]};
    endfunction

    function automatic logic [15:0] obs(input int i);
        return {3'b000, st[i], rw[i], mw[i], asrc[i], pw[i], aop[i], m2r[i], hlt[i], ill[i]};
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_dut%0d_outputs", tag, i), obs(i), expv(i));
`ifdef CPU_CTRL_PERF_EN
            chk($sformatf("%s_dut%0d_retired", tag, i), ret[i], 16'(m_ret[i]));
            chk($sformatf("%s_dut%0d_cycles", tag, i), cyc[i], 16'(m_cyc[i]));
`endif
        end
    endtask

    task automatic tick(input string tag);
        logic [15:0] e;
        for (int i = 0; i < 2; i++) begin
            e = expv(i);
`ifdef CPU_CTRL_PERF_EN
            if (e[6]) m_ret[i]++;
            if (m_st[i] != 5) m_cyc[i]++;
`endif
            if (m_st[i] == 1) begin
                m_ir[i] = instruction_in;
                set_path(i, instruction_in[7:4]);
            end
            if (m_st[i] == 2 && undef_op(m_ir[i][7:4])) m_ill[i] = 1'b1;
            if (m_k[i] < m_n[i]) begin
                m_st[i] = m_path[i][m_k[i]];
                m_k[i]++;
            end else if (m_st[i] == 0 && run) begin
                m_st[i] = 1;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_ir[i] = 8'h00; m_ill[i] = 1'b0; m_n[i] = 0; m_k[i] = 0;
`ifdef CPU_CTRL_PERF_EN
            m_ret[i] = 0; m_cyc[i] = 0;
`endif
        end
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset    = 1'b1;
        halt_cnt = 0;
    endtask

    task automatic run_instr(input string tag, input logic [7:0] instr, input int n);
        instruction_in = instr;
        run            = 1'b1;
        repeat (n) tick(tag);
    endtask

    initial begin
        int nib;
        do_reset();

        run_instr("add", 8'h16, 4);
        run_instr("ld", 8'h7B, 5);
        run_instr("st", 8'h86, 4);
        run = 1'b0;
        repeat (10) tick("pause");
        run_instr("resume_add", 8'h16, 4);
        run_instr("addi", 8'h6F, 4);
        run_instr("xor", 8'h51, 4);
        run_instr("nop", 8'h00, 3);

        run_instr("hlt", 8'hF0, 4);
        repeat (6) begin
            run = ~run;
            tick("halt_run");
        end
        do_reset();

        run_instr("undef", 8'hA0, 3);
        run_instr("after_undef", 8'h16, 6);
        do_reset();

        run_instr("abort_add", 8'h16, 2);
        do_reset();
        run_instr("post_abort", 8'h24, 4);

        for (int n = 0; n < 600; n++) begin
            if (halt_cnt > 4 || $urandom_range(0, 79) == 0) do_reset();
            run = ($urandom_range(0, 3) != 0);
            nib = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 8)) : int'($urandom_range(9, 15));
            instruction_in = {4'(nib), 4'($urandom)};
            tick("rand");
            if (m_st[0] == 5) halt_cnt++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
